// File: rtl/game_control_fsm.sv
// Starflux game sequencer: frame tick, START/DRAW/UPDATE/PAUSE/GAMEOVER FSM.
// Drives one-hot datapath enables, pause flag, game-over cause and frame count.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   pause_req         one-cycle pulse, toggles pause in DRAW/UPDATE
//   restart           one-cycle pulse, synchronous return to START
//   ship_health       NUM_SHIPS packed health fields
//   score             current score
//   start_game_en,
//   ship_update_en,
//   grid_update_en,
//   write_en,
//   game_over_en      Moore enables decoded from the state
//   paused            high while in PAUSE
//   tick              one-cycle frame tick
//   ship_alive        per-ship nonzero-health flags (combinational)
//   over_cause        {score reached, all ships dead}, latched
//   frame_count       completed UPDATE->DRAW transitions
module game_control_fsm #(
  parameter int unsigned TICK_DIV  = 3_125_000,
  parameter int unsigned NUM_SHIPS = 2,
  parameter int unsigned HEALTH_W  = 4,
  parameter int unsigned SCORE_W   = 8,
  parameter logic [SCORE_W-1:0] WIN_SCORE = {SCORE_W{1'b1}},
  parameter int unsigned FRAME_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pause_req,
  input  logic                          restart,
  input  logic [NUM_SHIPS*HEALTH_W-1:0] ship_health,
  input  logic [SCORE_W-1:0]            score,
  output logic                          start_game_en,
  output logic                          ship_update_en,
  output logic                          grid_update_en,
  output logic                          write_en,
  output logic                          game_over_en,
  output logic                          paused,
  output logic                          tick,
  output logic [NUM_SHIPS-1:0]          ship_alive,
  output logic [1:0]                    over_cause,
  output logic [FRAME_W-1:0]            frame_count
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_DRAW   = 3'd1,
    S_UPDATE = 3'd2,
    S_PAUSE  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  state_t             saved_q, saved_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cause_q, cause_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic all_dead;
  logic score_hit;

  always_comb begin
    ship_alive = '0;
    for (int i = 0; i < int'(NUM_SHIPS); i++) begin
      ship_alive[i] = |ship_health[i*HEALTH_W +: HEALTH_W];
    end
  end

  assign all_dead  = ~|ship_alive;
  assign score_hit = (score >= WIN_SCORE);

  // The counter is frozen in PAUSE, so no tick can fire there.
  assign tick = (cnt_q == '0) && (state_q != S_PAUSE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_START;
      saved_q <= S_DRAW;
      cnt_q   <= RELOAD;
      cause_q <= 2'b00;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cause_d = cause_q;
    frame_d = frame_q;
    if (restart) begin
      state_d = S_START;
      cause_d = 2'b00;
      frame_d = '0;
    end else begin
      case (state_q)
        S_START: begin
          if (tick) state_d = S_DRAW;
        end
        S_DRAW: begin
          if (pause_req) begin
            saved_d = S_DRAW;
            state_d = S_PAUSE;
          end else if (tick) begin
            state_d = S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (all_dead || score_hit) begin
            state_d = S_OVER;
            cause_d = {score_hit, all_dead};
          end else if (pause_req) begin
            saved_d = S_UPDATE;
            state_d = S_PAUSE;
          end else if (tick) begin
            state_d = S_DRAW;
            frame_d = frame_q + FRAME_W'(1);
          end
        end
        S_PAUSE: begin
          if (pause_req) state_d = saved_q;
        end
        S_OVER: begin
          state_d = S_OVER;
        end
        default: begin
          state_d = S_START;
        end
      endcase
    end
  end

  // Tick counter. Entering PAUSE keeps the value it had on the
  // pause_req cycle so the frame resumes exactly where it stopped;
  // a tick already emitted on that cycle still reloads to avoid a
  // duplicate pulse after resume.
  always_comb begin
    if (restart ||
        (state_d == S_START && state_q != S_START)) begin
      cnt_d = RELOAD;
    end else if (state_q == S_PAUSE) begin
      cnt_d = cnt_q;
    end else if (cnt_q == '0) begin
      cnt_d = RELOAD;
    end else if (state_d == S_PAUSE) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Output decode
  always_comb begin
    start_game_en  = 1'b0;
    ship_update_en = 1'b0;
    grid_update_en = 1'b0;
    write_en       = 1'b0;
    game_over_en   = 1'b0;
    paused         = 1'b0;
    case (state_q)
      S_START: begin
        start_game_en = 1'b1;
        write_en      = 1'b1;
      end
      S_DRAW: begin
        write_en = 1'b1;
      end
      S_UPDATE: begin
        ship_update_en = 1'b1;
        grid_update_en = 1'b1;
      end
      S_PAUSE: begin
        paused = 1'b1;
      end
      S_OVER: begin
        game_over_en = 1'b1;
      end
      default: begin
        start_game_en = 1'b0;
      end
    endcase
  end

  assign over_cause  = cause_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_game_control_fsm.sv
// Self-checking bench for game_control_fsm (TICK_DIV=4, two ships).
// Directed scenarios followed by randomized play against a reference model.
module tb_game_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        pause_req;
  logic        restart;
  logic [7:0]  ship_health;
  logic [7:0]  score;
  logic        start_game_en;
  logic        ship_update_en;
  logic        grid_update_en;
  logic        write_en;
  logic        game_over_en;
  logic        paused;
  logic        tick;
  logic [1:0]  ship_alive;
  logic [1:0]  over_cause;
  logic [15:0] frame_count;

  int npass = 0;
  int ntotal = 0;

  game_control_fsm #(
    .TICK_DIV  (4),
    .NUM_SHIPS (2),
    .HEALTH_W  (4),
    .SCORE_W   (8),
    .WIN_SCORE (8'hFF),
    .FRAME_W   (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pause_req      (pause_req),
    .restart        (restart),
    .ship_health    (ship_health),
    .score          (score),
    .start_game_en  (start_game_en),
    .ship_update_en (ship_update_en),
    .grid_update_en (grid_update_en),
    .write_en       (write_en),
    .game_over_en   (game_over_en),
    .paused         (paused),
    .tick           (tick),
    .ship_alive     (ship_alive),
    .over_cause     (over_cause),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: game phase, cycles left until the frame tick,
  // phase to resume after pause, latched cause, frames completed.
  localparam int M_START = 0;
  localparam int M_DRAW  = 1;
  localparam int M_UPD   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_OVER  = 4;

  int          mst;
  int          msaved;
  int          mleft;
  logic [1:0]  mcause;
  int          mframes;

  function automatic void model_reset();
    mst     = M_START;
    msaved  = M_DRAW;
    mleft   = 3;
    mcause  = 2'b00;
    mframes = 0;
  endfunction

  function automatic bit model_tick();
    return (mst != M_PAUSE) && (mleft == 0);
  endfunction

  function automatic void model_step(
    input bit pr, input bit rs,
    input logic [7:0] h, input logic [7:0] sc
  );
    int  nxt;
    bit  dead;
    bit  win;
    bit  tk;
    dead = (h[3:0] == 0) && (h[7:4] == 0);
    win  = (sc == 8'hFF);
    tk   = model_tick();
    nxt  = mst;
    if (rs) begin
      nxt = M_START;
      mcause = 2'b00;
      mframes = 0;
    end else if (mst == M_UPD && (dead || win)) begin
      nxt = M_OVER;
      mcause = {win, dead};
    end else if (pr && (mst == M_DRAW || mst == M_UPD)) begin
      msaved = mst;
      nxt = M_PAUSE;
    end else if (pr && mst == M_PAUSE) begin
      nxt = msaved;
    end else if (tk) begin
      if (mst == M_START) nxt = M_DRAW;
      else if (mst == M_DRAW) nxt = M_UPD;
      else if (mst == M_UPD) begin
        nxt = M_DRAW;
        mframes = (mframes + 1) % 65536;
      end
    end
    if (rs || (nxt == M_START && mst != M_START)) mleft = 3;
    else if (mst == M_PAUSE) mleft = mleft;
    else if (tk) mleft = 3;
    else if (nxt == M_PAUSE) mleft = mleft;
    else mleft = mleft - 1;
    mst = nxt;
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [1:0] al;
    al = {ship_health[7:4] != 0, ship_health[3:0] != 0};
    chk("start_game_en", start_game_en, mst == M_START);
    chk("write_en", write_en, mst == M_START || mst == M_DRAW);
    chk("ship_update_en", ship_update_en, mst == M_UPD);
    chk("grid_update_en", grid_update_en, mst == M_UPD);
    chk("game_over_en", game_over_en, mst == M_OVER);
    chk("paused", paused, mst == M_PAUSE);
    chk("tick", tick, model_tick());
    chk("ship_alive", ship_alive, al);
    chk("over_cause", over_cause, mcause);
    chk("frame_count", frame_count, mframes);
  endtask

  task automatic step(
    input bit pr, input bit rs,
    input logic [7:0] h, input logic [7:0] sc
  );
    pause_req = pr;
    restart = rs;
    ship_health = h;
    score = sc;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step(pr, rs, h, sc);
    #1;
    pause_req = 1'b0;
    restart = 1'b0;
  endtask

  initial begin
    logic [7:0] h;
    logic [7:0] sc;
    bit pr;
    bit rs;

    reset = 1'b1;
    pause_req = 1'b0;
    restart = 1'b0;
    ship_health = 8'h33;
    score = 8'h00;
    model_reset();
    @(negedge clk);
    check_all();
    chk("reset_start_en", start_game_en, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Tick cadence and the first completed frame
    repeat (12) step(0, 0, 8'h33, 8'h00);
    chk("t1_frame_count", frame_count, 16'd1);
    chk("t1_in_draw", write_en, 1'b1);

    // One ship dies, then both
    repeat (4) step(0, 0, 8'h33, 8'h00);
    chk("t2_in_update", ship_update_en, 1'b1);
    step(0, 0, 8'h30, 8'h00);
    chk("t2_alive", ship_alive, 2'b10);
    chk("t2_still_update", ship_update_en, 1'b1);
    step(0, 0, 8'h00, 8'h00);
    chk("t2_game_over", game_over_en, 1'b1);
    chk("t2_cause", over_cause, 2'b01);

    // Restart from game over
    step(0, 1, 8'h33, 8'h00);
    chk("t5_start_en", start_game_en, 1'b1);
    chk("t5_cause", over_cause, 2'b00);
    chk("t5_frames", frame_count, 16'd0);
    step(0, 0, 8'h33, 8'h00);
    step(0, 0, 8'h33, 8'h00);
    chk("t5_no_tick_yet", tick, 1'b0);
    step(0, 0, 8'h33, 8'h00);
    chk("t5_first_tick", tick, 1'b1);
    step(0, 0, 8'h33, 8'h00);

    // Score win outranks a simultaneous pause request
    repeat (4) step(0, 0, 8'h33, 8'h00);
    chk("t3_in_update", ship_update_en, 1'b1);
    step(1, 0, 8'h33, 8'hFF);
    chk("t3_game_over", game_over_en, 1'b1);
    chk("t3_cause", over_cause, 2'b10);
    chk("t3_not_paused", paused, 1'b0);
    step(0, 1, 8'h33, 8'h00);

    // Pause mid-frame, resume keeps tick progress
    repeat (4) step(0, 0, 8'h33, 8'h00);
    step(0, 0, 8'h33, 8'h00);
    step(1, 0, 8'h33, 8'h00);
    chk("t4_paused", paused, 1'b1);
    repeat (10) begin
      step(0, 0, 8'h33, 8'h00);
      chk("t4_no_tick", tick, 1'b0);
    end
    step(1, 0, 8'h33, 8'h00);
    chk("t4_resumed_draw", write_en, 1'b1);
    step(0, 0, 8'h33, 8'h00);
    chk("t4_tick_early", tick, 1'b0);
    step(0, 0, 8'h33, 8'h00);
    chk("t4_tick", tick, 1'b1);
    step(0, 0, 8'h33, 8'h00);
    chk("t4_update", ship_update_en, 1'b1);

    // Asynchronous reset mid-UPDATE
    #2 reset = 1'b1;
    #1;
    chk("t6_async_start", start_game_en, 1'b1);
    chk("t6_async_ship", ship_update_en, 1'b0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    step(1, 0, 8'h33, 8'h00);
    chk("t6_pause_ignored", start_game_en, 1'b1);
    step(0, 1, 8'h33, 8'h00);
    chk("t6_restart_start", start_game_en, 1'b1);

    // Randomized play
    for (int i = 0; i < 800; i++) begin
      h[3:0] = ($urandom_range(0, 7) == 0) ? 4'd0
             : 4'($urandom_range(1, 15));
      h[7:4] = ($urandom_range(0, 7) == 0) ? 4'd0
             : 4'($urandom_range(1, 15));
      sc = ($urandom_range(0, 24) == 0) ? 8'hFF
         : 8'($urandom_range(0, 254));
      pr = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 24) == 0);
      step(pr, rs, h, sc);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
